load_fire_unit: RTL
===================

# load_fire_unit

Issues in-flight loads from the load queue to the data memory interface and reports their completion. Picks the oldest load whose address is valid and that has not yet executed, sends it through a valid/ready request port, and pulses `load_executed`/`load_executed_index` back to the load queue. It then waits for the memory response and drives `load_succeeded`, the ROB tag and the data back to the load queue and the CDB broadcaster. Only one load is outstanding at a time.

## Interface
- `XLEN`, 32, data/address width
- `ROB_TAG_WIDTH`, 32, ROB tag width
- `LDQ_SIZE`, 32, load queue entries; must be a power of two
---
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `ldq_valid`  in  LDQ_SIZE  entry allocated
- `ldq_address_valid`  in  LDQ_SIZE  address written by the AGU
- `ldq_executed`  in  LDQ_SIZE  load already sent to memory
- `ldq_sleeping`  in  LDQ_SIZE  load blocked on an older store; not eligible
- `ldq_address`  in  LDQ_SIZE×XLEN  per-entry address
- `ldq_rob_tag`  in  LDQ_SIZE×ROB_TAG_WIDTH  per-entry ROB tag
- `head`  in  clog2(LDQ_SIZE)  load queue head (oldest entry)
- `flush`  in  1  pipeline flush; abandon any in-flight load
- `load_executed`  out  1  one-cycle pulse when a request is accepted
- `load_executed_index`  out  clog2(LDQ_SIZE)  LDQ index of that load
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_address`  out  XLEN  load address
- `mem_resp_valid`  in  1  response for the outstanding request
- `mem_resp_data`  in  XLEN  loaded data
- `load_succeeded`  out  1  one-cycle pulse when the load completes
- `load_succeeded_rob_tag`  out  ROB_TAG_WIDTH  ROB tag of the completed load
- `load_succeeded_data`  out  XLEN  loaded data
- `busy`  out  1  state is not IDLE

## Operation
- Eligibility: an entry is eligible when `valid & address_valid & ~executed & ~sleeping`.
- Selection order: entries are ranked by age offset `(i - head) mod LDQ_SIZE`, and the lowest offset wins. The search wraps around the end of the queue; with head=30, entry 31 beats entry 1.
- FSM states and transitions:
  - **IDLE**:
    - If any entry is eligible and `flush` is low, latch its index, address and ROB tag, then go to REQ.
    - If no entry is eligible, stay in IDLE.
  - **REQ**: `mem_req_valid`=1 with the latched address. `mem_req_valid` stays high until the handshake completes or a flush occurs.
    - On `mem_req_ready`: go to WAIT.
    - On `flush` without `ready`: go to IDLE and drop `mem_req_valid` next cycle.
    - On `flush` together with `ready`: go to DRAIN.
  - **WAIT**: wait for the response.
    - On `mem_resp_valid` with `flush` low: register the data and tag, then go to IDLE.
    - On `mem_resp_valid` with `flush` high: discard the response and go to IDLE.
    - On `flush` without a response: go to DRAIN.
  - **DRAIN**: swallow the next `mem_resp_valid`, go to IDLE, and do not pulse `load_succeeded`. `flush` in DRAIN has no further effect.
- `load_executed` = `mem_req_valid & mem_req_ready & ~flush`, combinational. `load_executed_index` holds the latched index.
- The latched address, tag and index are stable from REQ entry until leaving WAIT/DRAIN. Changes to LDQ inputs during that window are ignored.
- Index arithmetic is modulo LDQ_SIZE, using natural wrap at `clog2(LDQ_SIZE)` bits.

## Timing
- Reset values: FSM in IDLE, and all outputs 0 (`mem_req_valid`, `mem_req_address`, `load_executed`, `load_executed_index`, `load_succeeded`, `load_succeeded_rob_tag`, `load_succeeded_data`, `busy`).
- Reset mid-operation abandons the in-flight load immediately; no `load_succeeded` is produced.
- Eligible entry seen in IDLE at cycle T → `mem_req_valid`=1 from T+1.
- Handshake at cycle A → `load_executed` high in A. The LDQ sets `executed` at the A edge; the FSM is in WAIT from A+1.
- `mem_resp_valid` at cycle R → `load_succeeded`=1 for exactly cycle R+1, with its tag and data. The FSM is in IDLE at R+1 and may select again in R+1, so the next `mem_req_valid` is at R+2 at the earliest.
- Minimum load-to-load issue interval with zero memory latency is 3 cycles.
- `mem_resp_valid` in IDLE or REQ is ignored (protocol error; asserted against in the testbench).

## Test plan
- Single load: entry 3 valid/address-valid, addr 0x100, tag 7; ready immediately; response 0xDEADBEEF after 2 cycles → `mem_req_valid` at T+1; `load_executed` with index 3; `load_succeeded`=1 for one cycle with tag 7, data 0xDEADBEEF.
- Age order and wrap: head=30, eligible entries 1 and 31 → entry 31 issued first. Entry 1 issued after the response, once the LDQ model has set `executed[31]`.
- Backpressure: `mem_req_ready` low for 4 cycles → `mem_req_valid` and address held constant; `load_executed` pulses only in the accepting cycle.
- Sleeping/ineligible: entries 0 (sleeping) and 2 (address not valid) → no request; clearing `sleeping[0]` → entry 0 issues 1 cycle later.
- Flush in WAIT: flush 1 cycle after the handshake; response 3 cycles later → FSM in DRAIN, no `load_succeeded`, `busy` falls the cycle after the response.
- Flush in REQ with ready low → `mem_req_valid` drops next cycle, no `load_executed`. Async reset asserted in WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/load_fire_unit.sv
// Load fire unit: picks the oldest eligible LDQ entry, issues it to data memory,
// and reports completion. At most one load is outstanding at a time.
module load_fire_unit #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [LDQ_SIZE-1:0]                 ldq_valid,
  input  logic [LDQ_SIZE-1:0]                 ldq_address_valid,
  input  logic [LDQ_SIZE-1:0]                 ldq_executed,
  input  logic [LDQ_SIZE-1:0]                 ldq_sleeping,
  input  logic [LDQ_SIZE-1:0][XLEN-1:0]       ldq_address,
  input  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] ldq_rob_tag,
  input  logic [$clog2(LDQ_SIZE)-1:0]         head,
  input  logic                                flush,
  output logic                                load_executed,
  output logic [$clog2(LDQ_SIZE)-1:0]         load_executed_index,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [XLEN-1:0]                     mem_req_address,
  input  logic                                mem_resp_valid,
  input  logic [XLEN-1:0]                     mem_resp_data,
  output logic                                load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]            load_succeeded_rob_tag,
  output logic [XLEN-1:0]                     load_succeeded_data,
  output logic                                busy
);
  localparam int IW = $clog2(LDQ_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                   r_state;
  logic [IW-1:0]            r_idx;
  logic [XLEN-1:0]          r_addr;
  logic [ROB_TAG_WIDTH-1:0] r_tag;
  logic                     r_req_valid;
  logic                     r_succ;
  logic [ROB_TAG_WIDTH-1:0] r_succ_tag;
  logic [XLEN-1:0]          r_succ_data;

  logic [LDQ_SIZE-1:0]      w_elig;
  logic                     w_any;
  logic [IW-1:0]            w_sel;

  // Walk offsets from youngest to oldest so the lowest age offset wins last.
  always_comb begin
    logic [IW-1:0] v_idx;
    w_elig = ldq_valid & ldq_address_valid & ~ldq_executed & ~ldq_sleeping;
    w_any  = |w_elig;
    w_sel  = head;
    v_idx  = '0;
    for (int off = LDQ_SIZE - 1; off >= 0; off--) begin
      v_idx = head + IW'(off);
      if (w_elig[v_idx]) w_sel = v_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_tag       <= '0;
      r_req_valid <= 1'b0;
      r_succ      <= 1'b0;
      r_succ_tag  <= '0;
      r_succ_data <= '0;
    end else begin
      r_succ <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && !flush) begin
            r_idx       <= w_sel;
            r_addr      <= ldq_address[w_sel];
            r_tag       <= ldq_rob_tag[w_sel];
            r_req_valid <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) begin
            // An accepted request still owes a response that must be swallowed.
            r_req_valid <= 1'b0;
            r_state     <= mem_req_ready ? S_DRAIN : S_IDLE;
          end else if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!flush) begin
              r_succ      <= 1'b1;
              r_succ_tag  <= r_tag;
              r_succ_data <= mem_resp_data;
            end
            r_state <= S_IDLE;
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_executed          = r_req_valid & mem_req_ready & ~flush;
  assign load_executed_index    = r_idx;
  assign mem_req_valid          = r_req_valid;
  assign mem_req_address        = r_addr;
  assign load_succeeded         = r_succ;
  assign load_succeeded_rob_tag = r_succ_tag;
  assign load_succeeded_data    = r_succ_data;
  assign busy                   = (r_state != S_IDLE);

endmodule
